slavefifo2b_streamout_sink: RTL and testbench
=============================================

# slavefifo2b_streamout_sink

Consumer stage directly downstream of the stream-OUT read controller in the FX3 slave-FIFO (2-bit address) path. It monitors the controller's `slrd_`/`sloe_` strobes, realigns them to the FX3 read-data latency, and captures each valid 32-bit word into a show-ahead FIFO. FPGA logic drains the FIFO through a valid/ready port. The block also provides overflow/occupancy status and an optional incrementing-pattern checker for link bring-up.

## Interface
Parameters:
- `RD_LATENCY`, 3: cycles from a `slrd_`+`sloe_`-low cycle to the corresponding word on `fx3_data`; legal range 1–4.
- `DEPTH`, 16: FIFO entries; power of two, 4–256.
- `AFULL_MARGIN`, 4: `fifo_afull` asserts when `count >= DEPTH-AFULL_MARGIN`.

Ports:
- `clk_100`  in  1  100 MHz clock; all logic is rising-edge.
- `reset_`  in  1  asynchronous, active-low reset.
- `slrd_`  in  1  read strobe from the stream-OUT controller; active low.
- `sloe_`  in  1  output enable from the stream-OUT controller; active low.
- `fx3_data`  in  32  registered FX3 DQ bus.
- `out_data`  out  32  head-of-FIFO word.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  downstream accepts `out_data` this cycle.
- `fifo_afull`  out  1  occupancy threshold flag, intended for top-level gating of FLAGC.
- `overflow`  out  1  sticky: at least one word was dropped.
- `stats_clr`  in  1  synchronous clear of `word_count`, `overflow`, `err_count` and the checker seed.
- `word_count`  out  32  words written into the FIFO; wraps at 2^32.
- `err_count`  out  16  pattern mismatches; saturating.

## Operation
- Strobe pipeline: `rd_pipe[0] <= ~slrd_ & ~sloe_`; each later stage copies the previous one, giving `RD_LATENCY` stages in total.
- Capture event: `cap = rd_pipe[RD_LATENCY-1]`. On a capture, `fx3_data` is the word to store.
- Push/pop rules:
  - `pop = out_valid & out_ready`.
  - `push = cap & (~full | pop)`.
  - `cap & full & ~pop` drops the word and sets `overflow`.
- FIFO storage:
  - `wr_ptr` and `rd_ptr` are `log2(DEPTH)` bits and wrap naturally.
  - `count` is `log2(DEPTH)+1` bits.
  - `full = (count == DEPTH)`; `empty = (count == 0)`.
  - A simultaneous push and pop leaves `count` unchanged. This is legal at full and, because of show-ahead, also at empty-plus-one.
- `out_data = mem[rd_ptr]` (combinational read of the register array). `out_valid = ~empty`.
- `word_count` increments on every push. Dropped words are not counted.
- `stats_clr` priority:
  - Clears the counters and `overflow` in the same cycle; a simultaneous increment is lost.
  - Does not flush the FIFO or the strobe pipeline.
- `sloe_` high with `slrd_` low is not a capture; the pipeline stage loads 0.

## Timing
- Reset values: `out_valid=0`, `out_data=mem[0]` (contents are don't-care; pointers are 0), `fifo_afull=0`, `overflow=0`, `word_count=0`, `err_count=0`, all `rd_pipe` stages 0.
- Reset asserted mid-burst discards in-flight strobes and FIFO contents. The block restarts empty.
- If `slrd_`/`sloe_` are low in cycle N, the word present on `fx3_data` in cycle N+`RD_LATENCY` is written at the edge ending that cycle.
- `out_valid` is high from cycle N+`RD_LATENCY`+1, so total latency is `RD_LATENCY`+1 cycles.
- Throughput is one word per clock, in and out.
- `fifo_afull`, `overflow` and `count` are registered or derived from registered state and update one cycle after the causing edge.

## Configuration
- `STREAMOUT_CHECK_EN` defined: the pattern checker is compiled in.
  - The first push after reset or `stats_clr` seeds `expected = data+1`.
  - Each later push compares `data` with `expected`. On mismatch, `err_count` increments (saturating at 16'hFFFF).
  - After every later push, `expected = data+1` (reseed after an error).
- `STREAMOUT_CHECK_EN` undefined: no checker logic; `err_count` is tied to 16'd0.

## Test plan
- Single read: `slrd_`/`sloe_` low for 1 cycle at N, `fx3_data`=32'hA5A5_0001 at N+3 -> `out_valid` rises at N+4 with `out_data`=32'hA5A5_0001; `word_count`=1.
- Burst of 20 words 0..19 with `out_ready`=0, `DEPTH`=16:
  - Words 0..15 stored; `fifo_afull` high after the 12th push.
  - 4 words dropped; `overflow`=1; `word_count`=16.
  - Draining yields 0..15 in order.
- Streaming at full with `out_ready`=1 continuously: 1000 consecutive words pass with no loss, `count` stays at 1, `overflow`=0.
- `sloe_` high while `slrd_` low for 5 cycles -> no push, `word_count` unchanged.
- Reset pulse mid-burst after 7 pushes -> all outputs return to reset values; the next read's word appears as the sole FIFO entry.
- With `STREAMOUT_CHECK_EN`: words 100,101,102,200,201 -> `err_count`=1; then `stats_clr` -> `err_count`=0, `word_count`=0, `overflow`=0.

Source files
------------

// File: rtl/slavefifo2b_streamout_sink_if.sv
// Stream-OUT sink bundle: FX3 read strobes and DQ bus in, valid/ready word stream out.
// The slave modport is the sink itself; master is whoever drives strobes and consumes words.
interface slavefifo2b_streamout_sink_if #(
    parameter int DATA_W = 32
);
    logic              slrd_;
    logic              sloe_;
    logic [DATA_W-1:0] fx3_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output slrd_, sloe_, fx3_data, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  slrd_, sloe_, fx3_data, out_ready,
        output out_data, out_valid
    );
endinterface

// File: rtl/slavefifo2b_streamout_sink.sv
// FX3 slave-FIFO stream-OUT sink: realigns slrd_/sloe_ to read latency, captures words into a show-ahead FIFO.
// Define STREAMOUT_CHECK_EN to compile in the incrementing-pattern checker feeding err_count.
module slavefifo2b_streamout_sink #(
    parameter int DATA_W       = 32,
    parameter int RD_LATENCY   = 3,
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                          clk_100,
    input  logic                          reset_,
    slavefifo2b_streamout_sink_if.slave   sif,
    output logic                          fifo_afull,
    output logic                          overflow,
    input  logic                          stats_clr,
    output logic [31:0]                   word_count,
    output logic [15:0]                   err_count
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_CNT = (AW+1)'(DEPTH - AFULL_MARGIN);
    localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [RD_LATENCY-1:0] rd_pipe;
    logic [DATA_W-1:0]     mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  cap;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;

    // Strobe stage boundary: a read cycle surfaces as cap exactly RD_LATENCY edges later.
    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= ~sif.slrd_ & ~sif.sloe_;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign cap  = rd_pipe[RD_LATENCY-1];
    assign full = (count == FULL_CNT);
    assign pop  = sif.out_valid & sif.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push = cap & (~full | pop);
    assign drop = cap & full & ~pop;

    // FIFO write stage boundary: storage carries no reset, only pointers and count do.
    always_ff @(posedge clk_100) begin
        if (push) begin
            mem[wr_ptr] <= sif.fx3_data;
        end
    end

    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign sif.out_data  = mem[rd_ptr];
    assign sif.out_valid = (count != '0);
    assign fifo_afull    = (count >= AFULL_CNT);

    // Statistics stage boundary: stats_clr wins over a same-cycle increment.
    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            word_count <= '0;
            overflow   <= 1'b0;
        end else if (stats_clr) begin
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) word_count <= word_count + 32'd1;
            if (drop) overflow   <= 1'b1;
        end
    end

`ifdef STREAMOUT_CHECK_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic              seeded;
    logic [DATA_W-1:0] expected;

    // Checker stage boundary: every push reseeds, so one bad word costs exactly one error.
    always_ff @(posedge clk_100) begin
        if (push) begin
            expected <= sif.fx3_data + DATA_W'(1);
        end
    end

    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            seeded    <= 1'b0;
            err_count <= '0;
        end else if (stats_clr) begin
            seeded    <= 1'b0;
            err_count <= '0;
        end else if (push) begin
            seeded <= 1'b1;
            if (seeded && (sif.fx3_data != expected)) begin
                err_count <= sat_inc16(err_count);
            end
        end
    end
`else
    assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_slavefifo2b_streamout_sink.sv
// Randomized bench for slavefifo2b_streamout_sink against a queue-based reference model.
// Model works from strobe history and a word queue; outputs are compared at every falling edge.
module tb_slavefifo2b_streamout_sink;

    localparam int L            = 3;
    localparam int DEPTH        = 16;
    localparam int AFULL_MARGIN = 4;

    logic        clk_100;
    logic        reset_;
    logic        stats_clr;
    logic        fifo_afull;
    logic        overflow;
    logic [31:0] word_count;
    logic [15:0] err_count;

    slavefifo2b_streamout_sink_if #(.DATA_W(32)) sif();

    slavefifo2b_streamout_sink #(
        .DATA_W       (32),
        .RD_LATENCY   (L),
        .DEPTH        (DEPTH),
        .AFULL_MARGIN (AFULL_MARGIN)
    ) dut (
        .clk_100    (clk_100),
        .reset_     (reset_),
        .sif        (sif.slave),
        .fifo_afull (fifo_afull),
        .overflow   (overflow),
        .stats_clr  (stats_clr),
        .word_count (word_count),
        .err_count  (err_count)
    );

    initial clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    int          vectors;
    int          miscompares;
    logic [31:0] q[$];
    bit          hist[$];
    logic [31:0] m_wc;
    bit          m_ovf;
    logic [15:0] m_err;
    bit          m_have;
    logic [31:0] m_prev;
    bit          last_push;
    logic [31:0] dcnt;
    logic [31:0] dq[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        q.delete();
        hist.delete();
        m_wc   = '0;
        m_ovf  = 1'b0;
        m_err  = '0;
        m_have = 1'b0;
        m_prev = '0;
    endfunction

    // Models the rising edge that follows the inputs currently driven.
    function automatic void step_model();
        bit strobe, cap, pop, push, drop;
        strobe = !sif.slrd_ && !sif.sloe_;
        hist.push_back(strobe);
        cap = 1'b0;
        if (hist.size() > L) begin
            cap = hist[0];
            hist.delete(0);
        end
        pop  = (q.size() != 0) && sif.out_ready;
        push = cap && ((q.size() < DEPTH) || pop);
        drop = cap && !push;
        if (pop)  q.delete(0);
        if (push) q.push_back(sif.fx3_data);
        last_push = push;
        if (stats_clr) begin
            m_wc   = '0;
            m_ovf  = 1'b0;
            m_err  = '0;
            m_have = 1'b0;
        end else begin
            if (push) m_wc = m_wc + 32'd1;
            if (drop) m_ovf = 1'b1;
`ifdef STREAMOUT_CHECK_EN
            if (push) begin
                if (m_have && (sif.fx3_data != m_prev + 32'd1) && (m_err != 16'hFFFF))
                    m_err = m_err + 16'd1;
                m_have = 1'b1;
                m_prev = sif.fx3_data;
            end
`endif
        end
    endfunction

    task automatic check_outputs();
        chk("out_valid", 32'(sif.out_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("out_data", sif.out_data, q[0]);
        chk("fifo_afull", 32'(fifo_afull), 32'(q.size() >= DEPTH - AFULL_MARGIN));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("word_count", word_count, m_wc);
        chk("err_count", 32'(err_count), 32'(m_err));
    endtask

    task automatic cyc(input logic rd_n, input logic oe_n, input logic rdy,
                       input logic clr, input logic [31:0] d);
        @(negedge clk_100);
        check_outputs();
        sif.slrd_     = rd_n;
        sif.sloe_     = oe_n;
        sif.out_ready = rdy;
        stats_clr     = clr;
        sif.fx3_data  = d;
        step_model();
    endtask

    task automatic run(input int n, input int p_rd, input int p_rdy, input int p_clr,
                       input bit oe_off, input int p_mis);
        logic rd_n, oe_n, rdy, clr;
        for (int i = 0; i < n; i++) begin
            rd_n = !(int'($urandom_range(99)) < p_rd);
            oe_n = oe_off ? 1'b1 : (rd_n ^ (int'($urandom_range(99)) < p_mis));
            rdy  = int'($urandom_range(99)) < p_rdy;
            clr  = int'($urandom_range(999)) < p_clr;
            cyc(rd_n, oe_n, rdy, clr, dcnt);
            if (last_push) begin
                dcnt = dcnt + 32'd1;
                if ($urandom_range(31) == 0) dcnt = dcnt + $urandom;
            end
        end
    endtask

    // Strobes dq.size() consecutive reads, presenting dq words L cycles later.
    task automatic burst_words(input logic rdy);
        int n;
        logic rd_n;
        logic [31:0] d;
        n = dq.size();
        for (int i = 0; i < n + L; i++) begin
            rd_n = (i < n) ? 1'b0 : 1'b1;
            d    = (i >= L) ? dq[i-L] : 32'hDEAD_0000;
            cyc(rd_n, rd_n, rdy, 1'b0, d);
        end
    endtask

    task automatic do_reset(input bit chk_first);
        @(negedge clk_100);
        if (chk_first) check_outputs();
        reset_        = 1'b0;
        sif.slrd_     = 1'b1;
        sif.sloe_     = 1'b1;
        sif.out_ready = 1'b0;
        stats_clr     = 1'b0;
        model_clear();
        #1;
        check_outputs();
        repeat (2) @(negedge clk_100);
        check_outputs();
        reset_ = 1'b1;
        step_model();
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        last_push     = 1'b0;
        dcnt          = 32'd0;
        reset_        = 1'b1;
        stats_clr     = 1'b0;
        sif.slrd_     = 1'b1;
        sif.sloe_     = 1'b1;
        sif.fx3_data  = '0;
        sif.out_ready = 1'b0;
        model_clear();
        do_reset(1'b0);

        // Single read
        dq.delete();
        dq.push_back(32'hA5A5_0001);
        burst_words(1'b0);
        run(4, 0, 0, 0, 1'b0, 0);
        run(3, 0, 100, 0, 1'b0, 0);

        // 20-word burst into a stalled FIFO, then drain
        run(20, 100, 0, 0, 1'b0, 0);
        run(L + 2, 0, 0, 0, 1'b0, 0);
        run(DEPTH + 4, 0, 100, 0, 1'b0, 0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, dcnt);

        // Continuous streaming from empty, then at full
        run(1000, 100, 100, 0, 1'b0, 0);
        run(20, 100, 0, 0, 1'b0, 0);
        run(400, 100, 100, 0, 1'b0, 0);
        run(DEPTH + L + 2, 0, 100, 0, 1'b0, 0);

        // sloe_ held high while slrd_ low
        run(5, 100, 0, 0, 1'b1, 0);
        run(L + 2, 0, 0, 0, 1'b0, 0);

        // Random mix including stats_clr and strobe disagreement
        run(3000, 50, 50, 5, 1'b0, 5);
        run(400, 80, 20, 2, 1'b0, 10);

        // Reset mid-burst after 7 pushes, then a lone read
        run(DEPTH + L + 2, 0, 100, 0, 1'b0, 0);
        run(7 + L, 100, 0, 0, 1'b0, 0);
        do_reset(1'b1);
        dq.delete();
        dq.push_back(32'h1234_5678);
        burst_words(1'b0);
        run(4, 0, 0, 0, 1'b0, 0);
        run(3, 0, 100, 0, 1'b0, 0);

        // Pattern checker sequence, then stats_clr
        cyc(1'b1, 1'b1, 1'b1, 1'b1, dcnt);
        dq.delete();
        dq.push_back(32'd100);
        dq.push_back(32'd101);
        dq.push_back(32'd102);
        dq.push_back(32'd200);
        dq.push_back(32'd201);
        burst_words(1'b0);
        run(3, 0, 0, 0, 1'b0, 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, dcnt);
        run(10, 0, 100, 0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule
